// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word hold buffer, so consecutive words
// leave on sout with no idle cycle between them.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic             state_dbg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [WIDTH-1:0] hbuf, hbuf_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             hvalid, hvalid_nxt;
    logic [WIDTH-1:0] sreg_shift;
    logic             out_bit;
    logic             accept;

    // Handshake: a word transfers on a rising edge where load && ready are both
    // high; upstream holds data_in stable until that edge.
    assign ready  = clr && ((state == IDLE) || !hvalid);
    assign accept = load && ready;

    assign sreg_shift = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0}
                                         : {1'b0, sreg[WIDTH-1:1]};
    assign out_bit    = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];

    assign sout_valid = (state == SHIFT);
    assign sout       = sout_valid && out_bit;
    assign done       = sout_valid && (cnt == LAST);
    assign state_dbg  = (state == SHIFT);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            sreg   <= '0;
            hbuf   <= '0;
            cnt    <= '0;
            hvalid <= 1'b0;
        end else begin
            state  <= state_nxt;
            sreg   <= sreg_nxt;
            hbuf   <= hbuf_nxt;
            cnt    <= cnt_nxt;
            hvalid <= hvalid_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sreg_nxt   = sreg;
        hbuf_nxt   = hbuf;
        cnt_nxt    = cnt;
        hvalid_nxt = hvalid;
        case (state)
            IDLE: begin
                if (accept) begin
                    sreg_nxt  = data_in;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    // Buffered word wins over a fresh one; ready is low then anyway.
                    if (hvalid) begin
                        sreg_nxt   = hbuf;
                        hvalid_nxt = 1'b0;
                        cnt_nxt    = '0;
                    end else if (accept) begin
                        sreg_nxt = data_in;
                        cnt_nxt  = '0;
                    end else begin
                        sreg_nxt  = '0;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    sreg_nxt = sreg_shift;
                    cnt_nxt  = cnt + 1'b1;
                    if (accept) begin
                        hbuf_nxt   = data_in;
                        hvalid_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share all
// inputs and are checked against a bit-queue reference model every cycle.
module tb_bit_serializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ready_m, sout_m, sout_valid_m, done_m, state_m;
    logic         ready_l, sout_l, sout_valid_l, done_l, state_l;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;

    // Expected serial bits still to appear, oldest first.
    logic exp_q_m[$];
    logic exp_q_l[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .clr(clr), .load(load), .data_in(data_in), .ready(ready_m),
        .sout(sout_m), .sout_valid(sout_valid_m), .done(done_m), .state_dbg(state_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .clr(clr), .load(load), .data_in(data_in), .ready(ready_l),
        .sout(sout_l), .sout_valid(sout_valid_l), .done(done_l), .state_dbg(state_l)
    );

    // Reference model: at most two words in flight, i.e. accept while at most
    // one word's worth of bits is still pending.
    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            exp_q_m.delete();
            exp_q_l.delete();
        end else begin
            logic acc;
            acc = load && (exp_q_m.size() <= W);
            if (exp_q_m.size() > 0) void'(exp_q_m.pop_front());
            if (exp_q_l.size() > 0) void'(exp_q_l.pop_front());
            if (acc) begin
                acc_cnt++;
                for (int i = 0; i < W; i++) begin
                    exp_q_m.push_back(data_in[W-1-i]);
                    exp_q_l.push_back(data_in[i]);
                end
            end
        end
    end

    // Scoreboard: compare every output of both instances on the falling edge.
    always @(negedge clk) begin
        logic ev, eb, ed, er;
        ev = clr && (exp_q_m.size() > 0);
        eb = ev && exp_q_m[0];
        ed = ev && ((exp_q_m.size() % W) == 1);
        er = clr && (exp_q_m.size() <= W);
        checks++;
        if ({sout_m, sout_valid_m, done_m, ready_m, state_m} !== {eb, ev, ed, er, ev}) begin
            errors++;
            $display("FAIL sb_msb t=%0t: sout/valid/done/ready/state got %b%b%b%b%b want %b%b%b%b%b",
                     $time, sout_m, sout_valid_m, done_m, ready_m, state_m, eb, ev, ed, er, ev);
        end
        ev = clr && (exp_q_l.size() > 0);
        eb = ev && exp_q_l[0];
        ed = ev && ((exp_q_l.size() % W) == 1);
        er = clr && (exp_q_l.size() <= W);
        checks++;
        if ({sout_l, sout_valid_l, done_l, ready_l, state_l} !== {eb, ev, ed, er, ev}) begin
            errors++;
            $display("FAIL sb_lsb t=%0t: sout/valid/done/ready/state got %b%b%b%b%b want %b%b%b%b%b",
                     $time, sout_l, sout_valid_l, done_l, ready_l, state_l, eb, ev, ed, er, ev);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 clr = 1'b0;
        #1;
        checks++;
        if ({sout_m, sout_valid_m, done_m, ready_m, sout_l, sout_valid_l, done_l, ready_l} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b%b%b%b %b%b%b%b want all 0", sout_m, sout_valid_m,
                     done_m, ready_m, sout_l, sout_valid_l, done_l, ready_l);
        end
        tick();
        tick();
        #2 clr = 1'b1;
        tick();
        checks++;
        if (ready_m !== 1'b1 || ready_l !== 1'b1 || sout_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready got %b/%b valid %b want 1/1 0", ready_m, ready_l, sout_valid_m);
        end
    endtask

    task automatic test_single(input logic [W-1:0] d);
        logic [W-1:0] col_m, col_l;
        int nd_m, nd_l, dat_m, dat_l, gaps;
        col_m = '0; col_l = '0; nd_m = 0; nd_l = 0; dat_m = 0; dat_l = 0; gaps = 0;
        load = 1'b1; data_in = d;
        tick();
        load = 1'b0;
        for (int i = 1; i <= W; i++) begin
            col_m = {col_m[W-2:0], sout_m};
            col_l = {sout_l, col_l[W-1:1]};
            if (done_m) begin nd_m++; dat_m = i; end
            if (done_l) begin nd_l++; dat_l = i; end
            if (!sout_valid_m || !sout_valid_l) gaps++;
            tick();
        end
        checks++;
        if (col_m !== d || col_l !== d) begin
            errors++;
            $display("FAIL single_bits: msb stream %h lsb stream %h want %h", col_m, col_l, d);
        end
        checks++;
        if (nd_m != 1 || dat_m != W || nd_l != 1 || dat_l != W || gaps != 0) begin
            errors++;
            $display("FAIL single_done: pulses %0d/%0d at %0d/%0d gaps %0d want 1/1 at %0d/%0d gaps 0",
                     nd_m, nd_l, dat_m, dat_l, gaps, W, W);
        end
        checks++;
        if (sout_valid_m !== 1'b0 || sout_valid_l !== 1'b0) begin
            errors++;
            $display("FAIL single_tail: valid after last bit got %b/%b want 0/0", sout_valid_m, sout_valid_l);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] col, dv;
        int ready_bad, gaps;
        logic r9;
        col = '0; dv = '0; ready_bad = 0; gaps = 0; r9 = 1'b0;
        load = 1'b1; data_in = 8'hF0;
        tick();
        load = 1'b0;
        for (int cyc = 1; cyc <= 2 * W; cyc++) begin
            if (cyc == 3) begin load = 1'b1; data_in = 8'h0F; end
            col = {col[2*W-2:0], sout_m};
            dv  = {dv[2*W-2:0], done_m};
            if (!sout_valid_m) gaps++;
            if (cyc >= 4 && cyc <= W && ready_m !== 1'b0) ready_bad++;
            if (cyc == W + 1) r9 = ready_m;
            tick();
            if (cyc == 3) load = 1'b0;
        end
        checks++;
        if (col !== 16'hF00F || gaps != 0) begin
            errors++;
            $display("FAIL b2b_stream: got %h gaps %0d want f00f gaps 0", col, gaps);
        end
        checks++;
        if (dv !== 16'h0101) begin
            errors++;
            $display("FAIL b2b_done: pulse mask %b want 0000000100000001", dv);
        end
        checks++;
        if (ready_bad != 0 || r9 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: high while buffered %0d times, cycle 9 ready %b want 0 and 1", ready_bad, r9);
        end
        checks++;
        if (sout_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail: valid got %b want 0", sout_valid_m);
        end
    endtask

    task automatic test_overflow();
        logic [3*W-1:0] col, dv;
        int c_acc, gaps;
        logic acc;
        col = '0; dv = '0; c_acc = 0; gaps = 0;
        load = 1'b1; data_in = 8'hF0;
        tick();
        load = 1'b0;
        for (int cyc = 1; cyc <= 3 * W; cyc++) begin
            if (cyc == 3) begin load = 1'b1; data_in = 8'h0F; end
            if (cyc == 4) begin load = 1'b1; data_in = 8'hAA; end
            col = {col[3*W-2:0], sout_m};
            dv  = {dv[3*W-2:0], done_m};
            if (!sout_valid_m) gaps++;
            acc = load && ready_m;
            if (cyc >= 4 && acc && c_acc == 0) c_acc = cyc;
            tick();
            if (acc) load = 1'b0;
        end
        load = 1'b0;
        checks++;
        if (c_acc != W + 1) begin
            errors++;
            $display("FAIL ovf_accept_cycle: C taken in cycle %0d want %0d", c_acc, W + 1);
        end
        checks++;
        if (col !== 24'hF00FAA || gaps != 0) begin
            errors++;
            $display("FAIL ovf_stream: got %h gaps %0d want f00faa gaps 0", col, gaps);
        end
        checks++;
        if (dv !== 24'h010101) begin
            errors++;
            $display("FAIL ovf_done: pulse mask %h want 010101", dv);
        end
    endtask

    task automatic test_continuous();
        int gaps, bad_done, bad_ready, k;
        logic acc;
        gaps = 0; bad_done = 0; bad_ready = 0; k = 0;
        load = 1'b1; data_in = W'($urandom);
        tick();
        data_in++;
        for (int cyc = 1; cyc <= 6 * W; cyc++) begin
            if (sout_valid_m !== 1'b1) gaps++;
            if (done_m !== ((cyc % W) == 0)) bad_done++;
            if (ready_m !== ((cyc % W) == 1)) bad_ready++;
            acc = ready_m;
            tick();
            if (acc) data_in++;
        end
        load = 1'b0;
        checks++;
        if (gaps != 0 || bad_done != 0) begin
            errors++;
            $display("FAIL cont_stream: gaps %0d misplaced done %0d want 0 0", gaps, bad_done);
        end
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("FAIL cont_ready: wrong ready in %0d cycles want 0", bad_ready);
        end
        while (sout_valid_m && k < 20) begin
            tick();
            k++;
        end
        checks++;
        if (sout_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL cont_drain: valid still %b after %0d cycles want 0", sout_valid_m, k);
        end
    endtask

    task automatic test_reset_mid();
        load = 1'b1; data_in = 8'hC3;
        tick();
        load = 1'b0;
        tick();
        load = 1'b1; data_in = 8'h3C;
        tick();
        load = 1'b0;
        checks++;
        if (ready_m !== 1'b0) begin
            errors++;
            $display("FAIL rmid_buffered: ready got %b want 0", ready_m);
        end
        tick();
        #2 clr = 1'b0;
        #1;
        checks++;
        if ({sout_m, sout_valid_m, done_m, ready_m, sout_l, sout_valid_l, done_l, ready_l} !== 8'h00) begin
            errors++;
            $display("FAIL rmid_async: got %b%b%b%b %b%b%b%b want all 0", sout_m, sout_valid_m,
                     done_m, ready_m, sout_l, sout_valid_l, done_l, ready_l);
        end
        tick();
        tick();
        #2 clr = 1'b1;
        tick();
        checks++;
        if (ready_m !== 1'b1 || sout_valid_m !== 1'b0 || done_m !== 1'b0) begin
            errors++;
            $display("FAIL rmid_release: ready/valid/done got %b%b%b want 100", ready_m, sout_valid_m, done_m);
        end
        test_single(8'h96);
    endtask

    task automatic test_random();
        int a0, nd;
        logic held;
        a0 = acc_cnt; nd = 0; held = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!held) begin
                load = ($urandom_range(0, 3) != 0);
                data_in = W'($urandom);
            end
            held = load && !ready_m;
            if (done_m) nd++;
            tick();
        end
        load = 1'b0;
        for (int i = 0; i < 2 * W + 2; i++) begin
            if (done_m) nd++;
            tick();
        end
        checks++;
        if (nd != acc_cnt - a0) begin
            errors++;
            $display("FAIL rand_done_count: %0d pulses want %0d", nd, acc_cnt - a0);
        end
    endtask

    initial begin
        test_reset();
        test_single(8'b1101_0010);
        test_single(8'h2D);
        tick();
        test_back_to_back();
        tick();
        test_overflow();
        tick();
        test_continuous();
        tick();
        test_reset_mid();
        tick();
        test_random();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
